// File: rtl/vga_pkg.sv
// Shared timing defaults and FSM state type for the VGA pixel stream block.
package vga_pkg;

  localparam int unsigned HDISP_DEF  = 800;
  localparam int unsigned HFP_DEF    = 40;
  localparam int unsigned HPULSE_DEF = 48;
  localparam int unsigned HBP_DEF    = 40;
  localparam int unsigned VDISP_DEF  = 480;
  localparam int unsigned VFP_DEF    = 13;
  localparam int unsigned VPULSE_DEF = 3;
  localparam int unsigned VBP_DEF    = 29;

  localparam int unsigned RGB_W = 24;

  typedef enum logic [1:0] {
    WAIT_FULL  = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } state_t;

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-MAX counter with an enable and a single-cycle wrap indication.
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int unsigned MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [$clog2(MAX)-1:0] count,
  output logic                   wrap_c
);

  localparam int unsigned W    = $clog2(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  // Wrap is asserted on the enabled cycle that rolls the count back to zero.
  assign wrap_c = en && (count == LAST);

  // Count register: advances when enabled, returns to zero after LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap_c ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_pixel_stream.sv
// Drains a show-ahead pixel FIFO into VGA raster timing; waits for FIFO fill
// and a frame boundary before streaming, and flags underrun stickily.
module vga_pixel_stream
  import vga_pkg::*;
#(
  parameter int unsigned HDISP  = HDISP_DEF,
  parameter int unsigned HFP    = HFP_DEF,
  parameter int unsigned HPULSE = HPULSE_DEF,
  parameter int unsigned HBP    = HBP_DEF,
  parameter int unsigned VDISP  = VDISP_DEF,
  parameter int unsigned VFP    = VFP_DEF,
  parameter int unsigned VPULSE = VPULSE_DEF,
  parameter int unsigned VBP    = VBP_DEF
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [23:0] fifo_rdata,
  input  logic        fifo_empty,
  input  logic        fifo_wfull,
  output logic        fifo_read,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        underrun
);

  localparam int unsigned HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int unsigned VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int unsigned HW     = $clog2(HTOTAL);
  localparam int unsigned VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_ACT_END  = HW'(HDISP);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(HDISP + HFP + HPULSE);
  localparam logic [VW-1:0] V_ACT_END  = VW'(VDISP);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(VDISP + VFP + VPULSE);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_wrap_c;
  logic          v_wrap_c;
  logic          active_c;
  logic          hs_n_c;
  logic          vs_n_c;
  logic          underrun_hit_c;
  state_t        state_q;
  state_t        state_d;

  vga_wrap_counter #(.MAX(HTOTAL)) u_hcnt (
    .clk    (pixel_clk),
    .rst    (pixel_rst),
    .en     (1'b1),
    .count  (hcnt),
    .wrap_c (h_wrap_c)
  );

  vga_wrap_counter #(.MAX(VTOTAL)) u_vcnt (
    .clk    (pixel_clk),
    .rst    (pixel_rst),
    .en     (h_wrap_c),
    .count  (vcnt),
    .wrap_c (v_wrap_c)
  );

  // Raster decode from the free-running counters.
  assign active_c = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
  assign hs_n_c   = !((hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END));
  assign vs_n_c   = !((vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END));

  // Pop only on visible pixels while streaming and data is present.
  assign fifo_read      = (state_q == RUN) && active_c && !fifo_empty && !pixel_rst;
  assign underrun_hit_c = (state_q == RUN) && active_c && fifo_empty;

  // State register.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_q <= WAIT_FULL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: arm on FIFO full, start streaming on the last pixel of a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FULL:  if (fifo_wfull) state_d = WAIT_FRAME;
      WAIT_FRAME: if (v_wrap_c)   state_d = RUN;
      RUN:        state_d = RUN;
      default:    state_d = WAIT_FULL;
    endcase
  end

  // Registered pixel pins and sticky underrun flag.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      underrun  <= 1'b0;
    end else begin
      VGA_HS    <= hs_n_c;
      VGA_VS    <= vs_n_c;
      VGA_BLANK <= active_c;
      VGA_R     <= fifo_read ? fifo_rdata[23:16] : 8'd0;
      VGA_G     <= fifo_read ? fifo_rdata[15:8]  : 8'd0;
      VGA_B     <= fifo_read ? fifo_rdata[7:0]   : 8'd0;
      underrun  <= underrun | underrun_hit_c;
    end
  end

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Self-checking bench for vga_pixel_stream using small raster parameters.
module tb_vga_pixel_stream;

  localparam int HDISP = 8, HFP = 2, HPULSE = 3, HBP = 2;
  localparam int VDISP = 4, VFP = 1, VPULSE = 2, VBP = 1;
  localparam int HT = HDISP + HFP + HPULSE + HBP;
  localparam int VT = VDISP + VFP + VPULSE + VBP;
  localparam int NPOS = HT * VT;

  logic        clk = 1'b0;
  logic        pixel_rst = 1'b1;
  logic [23:0] fifo_rdata = 24'd0;
  logic        fifo_empty = 1'b1;
  logic        fifo_wfull = 1'b0;
  logic        fifo_read;
  logic        VGA_HS, VGA_VS, VGA_BLANK, underrun;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  vga_pixel_stream #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .pixel_clk  (clk),
    .pixel_rst  (pixel_rst),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_wfull (fifo_wfull),
    .fifo_read  (fifo_read),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK  (VGA_BLANK),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  // Harness FIFO contents; head is presented show-ahead.
  logic [23:0] q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: raster position plus streaming status.
  int          p = 0;
  bit          armed = 0;
  bit          running = 0;
  bit          e_hs = 1, e_vs = 1, e_blank = 0, e_under = 0;
  logic [23:0] e_rgb = 24'd0;
  bit          last_rd = 0;
  int          rd_count = 0;

  task automatic drive_fifo();
    fifo_empty = (q.size() == 0);
    fifo_rdata = (q.size() != 0) ? q[0] : 24'($urandom);
  endtask

  // One pixel clock: check the pop request, advance the model, check outputs.
  task automatic step();
    int x, y;
    bit act, erd, rd;
    drive_fifo();
    @(negedge clk);
    x   = p % HT;
    y   = p / HT;
    act = (x < HDISP) && (y < VDISP);
    erd = running && act && (q.size() != 0) && !pixel_rst;
    total++;
    if (fifo_read !== erd) begin
      bad++;
      $display("FAIL fifo_read pos=%0d got=%b exp=%b", p, fifo_read, erd);
    end
    rd = (fifo_read === 1'b1);
    if (pixel_rst) begin
      p = 0; armed = 0; running = 0;
      e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = 24'd0; e_under = 0;
    end else begin
      e_hs    = !((x >= HDISP + HFP) && (x < HDISP + HFP + HPULSE));
      e_vs    = !((y >= VDISP + VFP) && (y < VDISP + VFP + VPULSE));
      e_blank = act;
      e_rgb   = erd ? q[0] : 24'd0;
      if (running && act && q.size() == 0) e_under = 1;
      if (!running) begin
        if (armed) begin
          if (p == NPOS - 1) begin running = 1; armed = 0; end
        end else if (fifo_wfull) begin
          armed = 1;
        end
      end
      p = (p + 1) % NPOS;
    end
    @(posedge clk);
    if (rd) begin
      void'(q.pop_front());
      rd_count++;
    end
    last_rd = rd;
    #1;
    total++;
    if (VGA_HS !== e_hs) begin bad++; $display("FAIL hs pos=%0d got=%b exp=%b", p, VGA_HS, e_hs); end
    total++;
    if (VGA_VS !== e_vs) begin bad++; $display("FAIL vs pos=%0d got=%b exp=%b", p, VGA_VS, e_vs); end
    total++;
    if (VGA_BLANK !== e_blank) begin bad++; $display("FAIL blank pos=%0d got=%b exp=%b", p, VGA_BLANK, e_blank); end
    total++;
    if ({VGA_R, VGA_G, VGA_B} !== e_rgb) begin
      bad++; $display("FAIL rgb pos=%0d got=%h exp=%h", p, {VGA_R, VGA_G, VGA_B}, e_rgb);
    end
    total++;
    if (underrun !== e_under) begin bad++; $display("FAIL underrun pos=%0d got=%b exp=%b", p, underrun, e_under); end
    drive_fifo();
  endtask

  task automatic test_reset();
    pixel_rst = 1'b1;
    fifo_wfull = 1'b0;
    repeat (3) step();
    total++;
    if ({VGA_HS, VGA_VS, VGA_BLANK, underrun} !== 4'b1100 || {VGA_R, VGA_G, VGA_B} !== 24'd0) begin
      bad++;
      $display("FAIL reset_vals got=%b%b%b%b rgb=%h exp=1100 rgb=000000",
               VGA_HS, VGA_VS, VGA_BLANK, underrun, {VGA_R, VGA_G, VGA_B});
    end
  endtask

  task automatic test_hsync();
    bit hs[1:30];
    int first, width, second;
    pixel_rst = 1'b0;
    for (int s = 1; s <= 30; s++) begin
      step();
      hs[s] = VGA_HS;
    end
    first = -1; width = 0; second = -1;
    for (int s = 1; s <= 30; s++) begin
      if (!hs[s]) begin
        if (first < 0) first = s;
        else if (second < 0 && hs[s-1]) second = s;
        if (second < 0) width++;
      end
    end
    total++;
    if (first != 11) begin bad++; $display("FAIL hs_first got=%0d exp=11", first); end
    total++;
    if (width != 3) begin bad++; $display("FAIL hs_width got=%0d exp=3", width); end
    total++;
    if (second != 26) begin bad++; $display("FAIL hs_period got=%0d exp=26", second); end
  endtask

  task automatic test_vsync_blank();
    int vs_low, blank_hi, stray, vs_first;
    while (p != 0) step();
    vs_low = 0; blank_hi = 0; stray = 0; vs_first = -1;
    for (int s = 1; s <= NPOS; s++) begin
      step();
      if (!VGA_VS) begin
        vs_low++;
        if (vs_first < 0) vs_first = s;
      end
      if (VGA_BLANK) begin
        blank_hi++;
        if ((s - 1) / HT >= VDISP) stray++;
      end
    end
    total++;
    if (vs_low != 2 * HT) begin bad++; $display("FAIL vs_width got=%0d exp=%0d", vs_low, 2 * HT); end
    total++;
    if (vs_first != 5 * HT + 1) begin bad++; $display("FAIL vs_first got=%0d exp=%0d", vs_first, 5 * HT + 1); end
    total++;
    if (blank_hi != HDISP * VDISP || stray != 0) begin
      bad++; $display("FAIL blank_count got=%0d stray=%0d exp=%0d", blank_hi, stray, HDISP * VDISP);
    end
  endtask

  task automatic test_hold_off();
    int reads, nz;
    fifo_wfull = 1'b0;
    for (int i = 0; i < 20; i++) q.push_back(24'($urandom));
    reads = 0; nz = 0;
    for (int s = 0; s < NPOS + 7; s++) begin
      step();
      if (last_rd) reads++;
      if ({VGA_R, VGA_G, VGA_B} != 24'd0) nz++;
    end
    total++;
    if (reads != 0 || nz != 0) begin bad++; $display("FAIL hold_off reads=%0d rgb_nonzero=%0d exp=0", reads, nz); end
  endtask

  task automatic test_stream();
    int p0, s, first_s, cnt;
    logic [23:0] expect_pix;
    bit seq_ok;
    q.delete();
    while (p != 37) step();
    for (int i = 1; i <= 32; i++) q.push_back(24'(i));
    fifo_wfull = 1'b1;
    p0 = p;
    s = 0; first_s = -1;
    while (first_s < 0 && s < 3 * NPOS) begin
      s++;
      step();
      if (last_rd) first_s = s;
    end
    total++;
    if (first_s != NPOS - p0 + 1) begin bad++; $display("FAIL arm_first_read got=%0d exp=%0d", first_s, NPOS - p0 + 1); end
    total++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h000001) begin bad++; $display("FAIL first_pixel got=%h exp=000001", {VGA_R, VGA_G, VGA_B}); end
    cnt = 1; expect_pix = 24'h000002; seq_ok = 1;
    while (p != 0) begin
      step();
      if (last_rd) cnt++;
      if (VGA_BLANK) begin
        if ({VGA_R, VGA_G, VGA_B} !== expect_pix) seq_ok = 0;
        expect_pix = expect_pix + 24'd1;
      end
      if (p == NPOS - 2) for (int i = 0; i < 21; i++) q.push_back(24'h100 + 24'(i));
    end
    total++;
    if (cnt != 32) begin bad++; $display("FAIL pops_per_frame got=%0d exp=32", cnt); end
    total++;
    if (!seq_ok) begin bad++; $display("FAIL rgb_sequence got=broken exp=contiguous"); end
  endtask

  task automatic test_underrun();
    bit u_prev;
    for (int s = 1; s <= 2 * HT + 6; s++) begin
      u_prev = underrun;
      step();
    end
    total++;
    if (u_prev !== 1'b0 || underrun !== 1'b1) begin
      bad++; $display("FAIL underrun_edge got=%b%b exp=01", u_prev, underrun);
    end
    repeat (NPOS) step();
    total++;
    if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky got=%b exp=1", underrun); end
  endtask

  task automatic test_midline_reset();
    for (int i = 0; i < 40; i++) q.push_back(24'($urandom));
    while (p != HT + 4) step();
    pixel_rst = 1'b1;
    step();
    total++;
    if ({VGA_HS, VGA_VS, VGA_BLANK, underrun} !== 4'b1100 || {VGA_R, VGA_G, VGA_B} !== 24'd0) begin
      bad++; $display("FAIL midline_reset got=%b%b%b%b exp=1100", VGA_HS, VGA_VS, VGA_BLANK, underrun);
    end
    pixel_rst = 1'b0;
    repeat (2 * NPOS) step();
  endtask

  task automatic test_random();
    for (int s = 0; s < 1500; s++) begin
      if ($urandom_range(0, 99) < 40 && q.size() < 64) q.push_back(24'($urandom));
      fifo_wfull = ($urandom_range(0, 99) < 10);
      pixel_rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    pixel_rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_vsync_blank();
    test_hold_off();
    test_stream();
    test_underrun();
    test_midline_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
